synth_pipe_bench: RTL and testbench

// Parametrised, pipelined synthetic benchmark circuit for the ckt_tools flow.
// - Generalises the flat combinational generated benchmarks: WIDTH inputs pass

---
 rtl/synth_pipe_bench.sv | 156 +++++++++++++++
 tb/tb_synth_pipe_bench.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/synth_pipe_bench.sv
// -----------------------------------------------------------------------------
// synth_pipe_bench
//
// Pipelined synthetic benchmark circuit. WIDTH-bit vectors pass through STAGES
// registered layers of mixed 4-input gates. Each layer bit i combines
// x[i], x[i+1], x[i+3], x[i+7] (indices modulo WIDTH). The gate is picked by
// (i + stage) % 4: xor4, xnor4, and-or, or-and-not. An on-chip MISR and a
// transaction counter give sequential tools a checkable golden response.
//
// Handshake: a transfer happens on a rising clk edge where valid & ready are
// both 1. The sender holds valid and data stable until that edge. ready may
// depend combinationally on the downstream ready. valid never depends on ready.
//
// Ports
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      in_data is valid
//   in_ready   out  1      block accepts in_data this cycle
//   in_data    in   WIDTH  input vector
//   out_valid  out  1      out_data is valid
//   out_ready  in   1      sink accepts out_data this cycle
//   out_data   out  WIDTH  result of the final layer
//   sig_clr    in   1      synchronous clear of signature and counter
//   sig        out  WIDTH  MISR signature of all accepted outputs
//   txn_cnt    out  CNT_W  number of output handshakes (wraps)
// -----------------------------------------------------------------------------
module synth_pipe_bench #(
    parameter int          WIDTH  = 32,
    parameter int          STAGES = 3,
    parameter logic [31:0] POLY   = 32'h04C11DB7,
    parameter int          CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             sig_clr,
    output logic [WIDTH-1:0] sig,
    output logic [CNT_W-1:0] txn_cnt
);

    localparam logic [WIDTH-1:0] POLY_W = WIDTH'(POLY);

    // Repeating 0001 pattern: bit set wherever i % 4 == 0.
    function automatic logic [WIDTH-1:0] rep_mask();
        logic [WIDTH-1:0] m;
        m = '0;
        for (int k = 0; k < WIDTH; k += 4) begin
            m = m | (WIDTH'(1) << k);
        end
        return m;
    endfunction

    localparam logic [WIDTH-1:0] REP = rep_mask();

    // Rotate right, so that bit i of the result is x[(i + n) % WIDTH].
    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input int n);
        return (x >> n) | (x << (WIDTH - n));
    endfunction

    // One gate layer. The whole vector is evaluated with every gate type.
    // A per-stage mask then selects the gate for each bit. Gate g applies to
    // bits with (i + s) % 4 == g, that is i % 4 == (g - s) mod 4.
    function automatic logic [WIDTH-1:0] layer(input logic [WIDTH-1:0] x, input int s);
        logic [WIDTH-1:0] a, b, c, d, xo, m0, m1, m2, m3;
        a  = x;
        b  = rotr(x, 1);
        c  = rotr(x, 3);
        d  = rotr(x, 7);
        xo = a ^ b ^ c ^ d;
        m0 = REP << ((4 - (s % 4)) % 4);
        m1 = REP << ((5 - (s % 4)) % 4);
        m2 = REP << ((6 - (s % 4)) % 4);
        m3 = REP << ((7 - (s % 4)) % 4);
        return (xo & m0) | (~xo & m1) | (((a & b) | (c & d)) & m2)
             | (((a | b) & ~(c & d)) & m3);
    endfunction

    logic [WIDTH-1:0]  data_q    [STAGES];
    logic [WIDTH-1:0]  layer_out [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] ready;
    logic [STAGES-1:0] in_v;
    logic [WIDTH-1:0]  sig_q, sig_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_hs;

    // Stage k can load when any stage at or after k is empty, or the sink is
    // ready. This is the unrolled form of ready_k = ~valid_k | ready_(k+1).
    // Bits below k are forced to 1 so that only stages k and later count.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            ready[k] = out_ready
                     | ~(&(valid_q | ({STAGES{1'b1}} >> (STAGES - k))));
        end
    end

    always_comb begin
        in_v[0]      = in_valid & ready[0];
        layer_out[0] = layer(in_data, 1);
        for (int k = 1; k < STAGES; k++) begin
            in_v[k]      = valid_q[k-1];
            layer_out[k] = layer(data_q[k-1], k + 1);
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign out_hs    = out_valid & out_ready;

    // Signature and counter next state. A clear in the same cycle as a
    // handshake restarts the signature from the word being handed off.
    always_comb begin
        sig_d = sig_q;
        cnt_d = cnt_q;
        if (sig_clr) begin
            sig_d = out_hs ? out_data : '0;
            cnt_d = out_hs ? CNT_W'(1) : '0;
        end else if (out_hs) begin
            sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY_W : '0) ^ out_data;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
            sig_q <= '0;
            cnt_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ready[k]) begin
                    valid_q[k] <= in_v[k];
                    // A bubble leaves the held data untouched.
                    if (in_v[k]) begin
                        data_q[k] <= layer_out[k];
                    end
                end
            end
            sig_q <= sig_d;
            cnt_q <= cnt_d;
        end
    end

    assign sig     = sig_q;
    assign txn_cnt = cnt_q;

endmodule

// File: tb/tb_synth_pipe_bench.sv
module tb_synth_pipe_bench;
  localparam int W = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main DUT, STAGES=3
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b1;
  logic         sig_clr = 1'b0;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data, sig;
  logic [15:0]  txn_cnt;

  synth_pipe_bench #(.WIDTH(W), .STAGES(3), .POLY(32'h04C11DB7), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sig_clr(sig_clr), .sig(sig), .txn_cnt(txn_cnt)
  );

  // single-stage DUT
  logic         in_valid1 = 1'b0;
  logic [W-1:0] in_data1 = '0;
  logic         out_ready1 = 1'b1;
  logic         sig_clr1 = 1'b0;
  logic         in_ready1, out_valid1;
  logic [W-1:0] out_data1, sig1;
  logic [15:0]  txn_cnt1;

  synth_pipe_bench #(.WIDTH(W), .STAGES(1), .POLY(32'h04C11DB7), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .sig_clr(sig_clr1), .sig(sig1), .txn_cnt(txn_cnt1)
  );

  // counters and scoreboard state
  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] sig_m = '0;
  logic [15:0]  cnt_m = '0;
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  bit           rand_ready = 1'b0;

  // hand-computed three-stage results
  logic [W-1:0] vec  [4] = '{32'h00000000, 32'hFFFFFFFF, 32'hAAAAAAAA, 32'h55555555};
  logic [W-1:0] exp3 [4] = '{32'h44444444, 32'h55555555, 32'hBBBBBBBB, 32'h77777777};

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // reference model, used for the random stream
  function automatic logic [W-1:0] ref_layer(input logic [W-1:0] x, input int s);
    logic [W-1:0] y;
    logic a, b, c, d;
    y = '0;
    for (int i = 0; i < W; i++) begin
      a = x[i]; b = x[(i+1)%W]; c = x[(i+3)%W]; d = x[(i+7)%W];
      case ((i + s) % 4)
        0:       y[i] = a ^ b ^ c ^ d;
        1:       y[i] = ~(a ^ b ^ c ^ d);
        2:       y[i] = (a & b) | (c & d);
        default: y[i] = (a | b) & ~(c & d);
      endcase
    end
    return y;
  endfunction

  function automatic logic [W-1:0] ref_pipe(input logic [W-1:0] x, input int n);
    logic [W-1:0] v;
    v = x;
    for (int s = 1; s <= n; s++) v = ref_layer(v, s);
    return v;
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // caller is just after a rising edge; returns just after the accepting edge
  task automatic send(input logic [W-1:0] v, input logic [W-1:0] e);
    bit took;
    took = 1'b0;
    in_valid = 1'b1;
    in_data  = v;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        took = 1'b1;
        break;
      end
    end
    if (took) exp_q.push_back(e);
    else chk("send_timeout", W'(0), W'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 300; n++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_left", W'(exp_q.size()), W'(0));
  endtask

  // random out_ready during the stream
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // monitor: pops expected words on every output handshake and tracks the MISR
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      sig_m = '0;
      cnt_m = '0;
      prev_stall = 1'b0;
    end else begin
      chk("sig", sig, sig_m);
      chk("txn_cnt", W'(txn_cnt), W'(cnt_m));
      if (prev_stall) begin
        chk("stall_valid", W'(out_valid), W'(1));
        chk("stall_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %h expected no output", out_data);
        end else begin
          chk("out_data", out_data, exp_q.pop_front());
        end
        if (sig_clr) begin
          sig_m = out_data;
          cnt_m = 16'd1;
        end else begin
          sig_m = {sig_m[W-2:0], 1'b0} ^ (sig_m[W-1] ? 32'h04C11DB7 : 32'h0) ^ out_data;
          cnt_m = cnt_m + 16'd1;
        end
      end else if (sig_clr) begin
        sig_m = '0;
        cnt_m = '0;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // stimulus
  initial begin
    int n, acc, idx, seen;
    bit took;
    logic [W-1:0] v;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_data", out_data, W'(0));
    chk("rst_sig", sig, W'(0));
    chk("rst_txn_cnt", W'(txn_cnt), W'(0));
    chk("rst_out_valid1", W'(out_valid1), W'(0));
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", W'(in_ready), W'(1));

    // single stage: zero and all-ones
    step();
    in_valid1 = 1'b1;
    in_data1  = 32'h00000000;
    @(negedge clk);
    chk("s1_in_ready", W'(in_ready1), W'(1));
    step();
    in_data1 = 32'hFFFFFFFF;
    @(negedge clk);
    chk("s1_valid_a", W'(out_valid1), W'(1));
    chk("s1_data_zero", out_data1, 32'h11111111);
    step();
    in_valid1 = 1'b0;
    @(negedge clk);
    chk("s1_data_ones", out_data1, 32'h33333333);
    chk("s1_sig_a", sig1, 32'h11111111);
    chk("s1_cnt_a", W'(txn_cnt1), W'(1));
    step();
    @(negedge clk);
    chk("s1_valid_end", W'(out_valid1), W'(0));
    chk("s1_sig_b", sig1, 32'h11111111);
    chk("s1_cnt_b", W'(txn_cnt1), W'(2));

    // latency from idle
    step();
    send(vec[0], exp3[0]);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    chk("latency", W'(n), W'(3));
    drain();

    // directed vectors back to back
    step();
    for (int i = 0; i < 4; i++) send(vec[i], exp3[i]);
    drain();

    // random stream with random back-pressure
    step();
    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      v = $urandom;
      send(v, ref_pipe(v, 3));
    end
    drain();
    rand_ready = 1'b0;
    step();
    out_ready = 1'b1;

    // stall: output blocked while input keeps offering
    step();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    idx = 0;
    acc = 0;
    in_data = vec[0];
    for (int c = 0; c < 10; c++) begin
      took = 1'b0;
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(exp3[idx]);
        acc++;
        took = 1'b1;
      end
      step();
      if (took) begin
        idx = (idx + 1) % 4;
        in_data = vec[idx];
      end
    end
    @(negedge clk);
    chk("stall_accepted", W'(acc), W'(3));
    chk("stall_in_ready", W'(in_ready), W'(0));
    chk("stall_head", out_data, 32'h44444444);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // clear together with a handshake of value 0x44444444
    step();
    out_ready = 1'b0;
    send(vec[0], exp3[0]);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    step();
    out_ready = 1'b1;
    sig_clr   = 1'b1;
    step();
    sig_clr = 1'b0;
    @(negedge clk);
    chk("clr_hs_sig", sig, 32'h44444444);
    chk("clr_hs_cnt", W'(txn_cnt), W'(1));

    // clear without a handshake
    step();
    sig_clr = 1'b1;
    step();
    sig_clr = 1'b0;
    @(negedge clk);
    chk("clr_sig", sig, W'(0));
    chk("clr_cnt", W'(txn_cnt), W'(0));

    // reset with two vectors in flight
    step();
    send(vec[1], exp3[1]);
    send(vec[2], exp3[2]);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_valid", W'(out_valid), W'(0));
    chk("midrst_sig", sig, W'(0));
    chk("midrst_cnt", W'(txn_cnt), W'(0));
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_no_output", W'(seen), W'(0));

    // pipeline works again after reset
    step();
    send(vec[3], exp3[3]);
    drain();

    step();
    @(negedge clk);
    chk("queue_empty", W'(exp_q.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
